// File: rtl/softmax_normalizer.sv
// Iterative two's-complement normalizer for the Softmax datapath.
// Left-shifts one bit per cycle until the two top bits differ.
module softmax_normalizer #(
   parameter int INPUT_SIZE = 8,
   parameter int SHIFT_SIZE = $clog2(INPUT_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INPUT_SIZE-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [INPUT_SIZE-1:0] out_data,
   output logic [SHIFT_SIZE-1:0] out_shift,
   output logic                  out_zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [INPUT_SIZE-1:0] r_work;
   logic [SHIFT_SIZE-1:0] r_count;
   logic [INPUT_SIZE-1:0] r_data;
   logic [SHIFT_SIZE-1:0] r_shift;
   logic                  r_zero;
   logic                  w_accept;
   logic                  w_is_zero;
   logic                  w_is_norm;

   assign w_accept  = in_valid && in_ready;
   assign w_is_zero = (r_work == '0);
   assign w_is_norm = r_work[INPUT_SIZE-1] ^ r_work[INPUT_SIZE-2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept) w_next = SHIFT;
         end
         SHIFT: begin
            if (w_is_zero || w_is_norm) w_next = DONE;
         end
         DONE: begin
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so it reads 0 while reset is held
   always_comb begin
      in_ready  = rst_n && (r_state == IDLE);
      out_valid = (r_state == DONE);
      out_data  = r_data;
      out_shift = r_shift;
      out_zero  = r_zero;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work  <= '0;
         r_count <= '0;
         r_data  <= '0;
         r_shift <= '0;
         r_zero  <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            if (w_accept) begin
               r_work  <= in_data;
               r_count <= '0;
            end
         end else if (r_state == SHIFT) begin
            if (w_is_zero) begin
               r_data  <= '0;
               r_shift <= '0;
               r_zero  <= 1'b1;
            end else if (w_is_norm) begin
               r_data  <= r_work;
               r_shift <= r_count;
               r_zero  <= 1'b0;
            end else begin
               r_work  <= r_work << 1;
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
- Iterative two's-complement normalizer for the Softmax vector datapath, i.e. the inverse of the fixed shifter.
- Takes a signed operand and left-shifts it one bit per cycle until the sign bit and next bit differ.
- Returns the normalized mantissa plus the shift count. Applying that count as an arithmetic right shift (direction = right) restores the original scale.
- Sits between the exponent-sum accumulator and the reciprocal/divide stage; valid/ready on both sides.

Parameters:
- INPUT_SIZE, 8, operand and mantissa width in bits (≥ 2).
- SHIFT_SIZE, $clog2(INPUT_SIZE), width of the shift-count output; must be able to hold INPUT_SIZE-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  INPUT_SIZE  signed operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  INPUT_SIZE  normalized mantissa: bit[INPUT_SIZE-1] != bit[INPUT_SIZE-2], or 0.
- out_shift  output  SHIFT_SIZE  number of left shifts applied.
- out_zero  output  1  operand was zero.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=0 while in reset, out_valid=0, out_data=0, out_shift=0, out_zero=0, internal regs cleared.
- Reset may assert in any state; any in-flight operand is discarded with no partial output.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data, clear the count, go to SHIFT.
- SHIFT (in_ready=0), evaluated each cycle on the working register:
  - Register is zero: set out_zero=1, out_shift=0, out_data=0, go to DONE.
  - bit[W-1] != bit[W-2]: latch out_data and out_shift=count, go to DONE.
  - Otherwise: shift left by 1 (zero fill), count+1, stay in SHIFT.
- Count never exceeds INPUT_SIZE-1. Worst case is the all-ones value -1, which reaches 100..0 after INPUT_SIZE-1 shifts. No saturation logic is needed.
- Latency: out_valid rises (out_shift + 1) rising edges after the accepting edge. A zero operand takes 1 edge.
- DONE:
  - out_valid=1; out_data, out_shift and out_zero are held stable while out_ready=0.
  - On out_ready, the next edge clears out_valid and returns to IDLE.
  - in_ready stays 0 in DONE (no overlap). Next accept is possible one cycle after the handshake.
- Non-blocking: out_data, out_shift and out_zero are meaningful only while out_valid=1, and hold their last value otherwise.
- in_valid while in_ready=0 is ignored; the producer must hold its data.
- out_shift is directly usable as the shift amount of the Softmax shifter with right-shift selected.

Test Plan (INPUT_SIZE=8):
- in_data=0x40 → out_data=0x40, out_shift=0, out_zero=0, out_valid 1 edge after accept.
- in_data=0x01 → out_data=0x40, out_shift=6, out_valid 7 edges after accept; in_ready=0 throughout.
- in_data=0xFF (-1) → out_data=0x80, out_shift=7; in_data=0xF0 (-16) → out_data=0x80, out_shift=3.
- in_data=0x00 → out_zero=1, out_data=0x00, out_shift=0, 1-edge latency.
- Hold out_ready=0 for 5 cycles after in_data=0x03 completes → outputs stable at 0x60/5. in_valid pulses are ignored and in_ready stays 0. Release → IDLE, next operand accepted.
- Assert rst_n=0 mid-SHIFT for in_data=0x01 → outputs go 0 immediately. After release, in_data=0x20 yields 0x40, shift 1, with no stale result.
